spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
- SPI responder (slave end), SPI mode 0 (CPOL=0, CPHA=0), MSB first, full duplex.
- Oversamples external sclk/cs_n/mosi in the system `clk` domain.
- Presents a parallel TX/RX handshake to local logic.
- Sits between the chip pins and the local register/data logic, opposite an SPI master; replaces an ad-hoc slave when talking to off-chip masters.

Parameters:
- DATA_W, 8, word width in bits (≥2).
- SYNC_STAGES, 2, synchronizer flops on sclk, cs_n and mosi (≥2).
- IDLE_FILL, 8'hFF, word shifted out on miso when no TX word is available (underrun).

Ports:
- clk  in  1  system clock; sclk must be ≤ clk/8.
- reset  in  1  synchronous, active-low reset.
- sclk  in  1  SPI clock from master, asynchronous.
- cs_n  in  1  chip select, active-low, asynchronous.
- mosi  in  1  master-out data, asynchronous.
- miso  out  1  slave-out data.
- miso_oe  out  1  miso output enable; high while selected.
- tx_data  in  DATA_W  next word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX holding register empty.
- rx_data  out  DATA_W  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.

Behaviour:
- Reset (reset==0 at a clk edge): all outputs and state cleared.
  - miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0.
  - Bit counter=0, FSM=IDLE, synchronizers loaded with sclk=0, cs_n=1, mosi=0.
- Synchronization: SYNC_STAGES flops per input. Edge detect on the last two synchronized sclk samples gives `rise`/`fall`. cs_n edges are detected the same way.
- TX holding register:
  - A write occurs when tx_valid & tx_ready; tx_ready drops the next cycle.
  - The holding register is consumed when its contents are copied into the shift register; tx_ready returns high the cycle after consumption.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: miso_oe=0, miso=0. Synchronized cs_n falling → LOAD.
  - LOAD (1 cycle):
    - Shift register ← holding register if full (consume), else IDLE_FILL.
    - Bit counter ← 0, miso_oe=1, miso = shift-register MSB → SHIFT.
  - SHIFT:
    - On `rise`: shift-in register ← {rx_sh[DATA_W-2:0], mosi_sync}; counter += 1.
    - On `fall` with counter != 0 and counter != DATA_W: tx shift left by 1; miso = new MSB.
    - When counter reaches DATA_W on a `rise`:
      - rx_data ← assembled word; rx_valid=1 for exactly the next cycle; counter ← 0.
      - Next word is loaded as in LOAD (holding or IDLE_FILL) at the following `fall`, so back-to-back words under a single cs_n work.
  - Any state: synchronized cs_n high → IDLE on the next cycle.
    - Partial word discarded; no rx_valid.
    - A word already in the shift register is lost; the holding register is untouched.
- Latency: rx_valid asserts within SYNC_STAGES+2 clk cycles after the DATA_W-th sclk rising edge at the pin.
- Simultaneous events:
  - tx write in the same cycle as a load: the load takes the old holding contents if full. If the holding register is empty, the load takes IDLE_FILL, and the new word waits for the next load.
  - cs_n rise on the same cycle as the final `rise`: the word completes and rx_valid pulses, then the FSM goes to IDLE.
- Reset mid-transfer: immediate return to the reset state. The master sees miso_oe=0.
- rx_data holds its value until the next complete word; there is no backpressure on RX.

Optional Feature:
- Macro SPI_SLAVE_STATUS_EN.
- Defined: adds outputs `overrun` and `underrun` (1 bit each, sticky, cleared by reset or an `status_clr` input pulse).
  - `overrun` sets when a word completes while the previous rx_valid word is unacknowledged. This uses an added `rx_ack` input; unacknowledged means no rx_ack since the last rx_valid.
  - `underrun` sets when a load uses IDLE_FILL while cs_n is low.
- Undefined: none of these ports or logic exist; behaviour is otherwise identical.

Test Plan:
- Basic exchange: tx_data=8'hCC written before select; master sends 8'hAA → rx_data=8'hAA with one rx_valid pulse; master receives 8'hCC on miso; tx_ready goes 0→1.
- Back-to-back: two words under one cs_n; master sends 8'h12, 8'h34; holding is refilled with 8'h5A after the first load → rx_valid pulses twice (8'h12, 8'h34); master receives 8'hCC, 8'h5A.
- Underrun: no TX write; master sends 8'h0F → master receives 8'hFF; rx_data=8'h0F; `underrun`=1 when SPI_SLAVE_STATUS_EN is defined.
- Abort: cs_n deasserted after 5 sclk edges → no rx_valid; rx_data keeps its previous value; miso_oe=0 within SYNC_STAGES+2 cycles; the next full transfer is correct.
- Reset mid-transfer: reset=0 for 1 cycle during bit 3 → all outputs at their reset values; FSM IDLE; a subsequent 8'hA5 transfer is received correctly.
- Slowest/fastest sclk: sclk = clk/8 and clk/64 with 8'h96 both ways → identical correct results.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI mode-0 responder (MSB first, full duplex); sclk/cs_n/mosi oversampled in clk.
// Latency: rx_valid SYNC_STAGES+1 clk after the last sclk rise reaches the pin; miso follows a sclk fall by SYNC_STAGES+1 clk.
// Backpressure: tx_valid/tx_ready on a one-word holding register, IDLE_FILL sent on underrun; RX has none.
// Optional: define SPI_SLAVE_STATUS_EN for sticky overrun/underrun flags with rx_ack/status_clr inputs.
module spi_slave_if #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL   = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid
`ifdef SPI_SLAVE_STATUS_EN
    ,
    input  logic              rx_ack,
    input  logic              status_clr,
    output logic              overrun,
    output logic              underrun
`endif
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   rise, fall, cs_fall;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_W-1:0]      tx_sh_q, hold_q, rx_data_q;
    logic [DATA_W-2:0]      rx_sh_q;
    logic                   tx_ready_q, rx_valid_q, miso_q, miso_oe_q;

    logic [DATA_W-1:0]      rx_word_d, load_word_d;
    logic                   word_done, do_load;

    // Synchronizer chains plus one history flop each for sclk/cs_n edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_prev_q;
    assign fall    = ~sclk_s & sclk_prev_q;
    assign cs_fall = ~cs_s & cs_prev_q;

    // A zero count on a fall only happens right after a completed word, so that fall reloads the shifter.
    assign rx_word_d   = {rx_sh_q, mosi_s};
    assign load_word_d = tx_ready_q ? IDLE_FILL : hold_q;
    assign word_done   = (state_q == SHIFT) && rise && (cnt_q == CNT_W'(DATA_W - 1));
    assign do_load     = !cs_s && ((state_q == LOAD) ||
                                   ((state_q == SHIFT) && fall && (cnt_q == '0)));

    // Transfer FSM, TX holding register and RX word assembly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_sh_q    <= '0;
            hold_q     <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            tx_ready_q <= 1'b1;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            // Write needs an empty holding register and consume needs a full one, so they never collide.
            if (tx_valid && tx_ready_q) begin
                hold_q     <= tx_data;
                tx_ready_q <= 1'b0;
            end
            if (do_load && !tx_ready_q) begin
                tx_ready_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    miso_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                    if (cs_fall) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (cs_s) begin
                        state_q   <= IDLE;
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                    end else begin
                        tx_sh_q   <= load_word_d;
                        miso_q    <= load_word_d[DATA_W-1];
                        miso_oe_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        rx_sh_q <= rx_word_d[DATA_W-2:0];
                        if (word_done) begin
                            rx_data_q  <= rx_word_d;
                            rx_valid_q <= 1'b1;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (fall) begin
                        if (cnt_q == '0) begin
                            tx_sh_q <= load_word_d;
                            miso_q  <= load_word_d[DATA_W-1];
                        end else begin
                            tx_sh_q <= {tx_sh_q[DATA_W-2:0], tx_sh_q[DATA_W-1]};
                            miso_q  <= tx_sh_q[DATA_W-2];
                        end
                    end
                    // Deselect wins over everything except completing a word on the same cycle.
                    if (cs_s) begin
                        state_q   <= IDLE;
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = miso_oe_q;
    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_STATUS_EN
    logic unacked_q, overrun_q, underrun_q;

    // Sticky flags: overrun when a word lands on an unacknowledged one, underrun when a load falls back to IDLE_FILL.
    always_ff @(posedge clk) begin
        if (!reset) begin
            unacked_q  <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (word_done) begin
                unacked_q <= 1'b1;
            end else if (rx_ack) begin
                unacked_q <= 1'b0;
            end
            if (status_clr) begin
                overrun_q  <= 1'b0;
                underrun_q <= 1'b0;
            end else begin
                if (word_done && unacked_q && !rx_ack) begin
                    overrun_q <= 1'b1;
                end
                if (do_load && tx_ready_q) begin
                    underrun_q <= 1'b1;
                end
            end
        end
    end

    assign overrun  = overrun_q;
    assign underrun = underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: an SPI mode-0 master model drives the pins, a holding-register queue predicts miso words.
module tb_spi_slave_if;
    logic       clk = 1'b0;
    logic       reset, sclk, cs_n, mosi, miso, miso_oe;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid;
`ifdef SPI_SLAVE_STATUS_EN
    logic       rx_ack, status_clr, overrun, underrun;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] m_tx [4];
    logic [7:0] m_rx [4];
    logic [7:0] rx_q [$];
    logic [7:0] model_q [$];
    logic [7:0] w0, w1;
    int         half, nw;
    bit         wr;

    always #5 clk = ~clk;

    spi_slave_if dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid)
`ifdef SPI_SLAVE_STATUS_EN
        , .rx_ack(rx_ack), .status_clr(status_clr), .overrun(overrun), .underrun(underrun)
`endif
    );

    // Every received word, in arrival order.
    always @(negedge clk) begin
        if (reset === 1'b1 && rx_valid === 1'b1) rx_q.push_back(rx_data);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holding register model: every load takes the oldest written word, or 8'hFF when none is waiting.
    function automatic logic [7:0] exp_word();
        if (model_q.size() > 0) return model_q.pop_front();
        return 8'hFF;
    endfunction

    task automatic write_tx(input logic [7:0] w);
        int t = 0;
        while (tx_ready !== 1'b1 && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk("tx_ready_before_write", {31'd0, tx_ready}, 1);
        tx_data  = w;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        model_q.push_back(w);
        chk("tx_ready_after_write", {31'd0, tx_ready}, 0);
    endtask

    // Mode-0 master: mosi changes after sclk falls, miso sampled on sclk rise; optional reset pulse after a rise.
    task automatic spi_xfer(input int nwords, input int hp, input int nbits, input int rst_bit);
        int w, i;
        @(posedge clk); #3;
        cs_n = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        for (int b = 0; b < nbits; b++) begin
            w = b / 8;
            i = 7 - (b % 8);
            mosi = m_tx[w][i];
            repeat (hp) @(posedge clk);
            #3;
            sclk = 1'b1;
            m_rx[w][i] = miso;
            if (b == 0) chk("miso_oe_selected", {31'd0, miso_oe}, 1);
            if (b == rst_bit) begin
                reset = 1'b0;
                @(posedge clk); #1;
                chk("rst_miso", {31'd0, miso}, 0);
                chk("rst_miso_oe", {31'd0, miso_oe}, 0);
                chk("rst_tx_ready", {31'd0, tx_ready}, 1);
                chk("rst_rx_data", {24'd0, rx_data}, 0);
                chk("rst_rx_valid", {31'd0, rx_valid}, 0);
                reset = 1'b1;
                model_q.delete();
            end
            repeat (hp) @(posedge clk);
            #3;
            sclk = 1'b0;
        end
        repeat (hp) @(posedge clk);
        #3;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("miso_oe_release", {31'd0, miso_oe}, 0);
        repeat (6) @(posedge clk);
        #1;
        if (nwords < 0) $display("[TB] unexpected word count");
    endtask

    // Full-word transfer; the fall after the last rise performs one more load, which the model also consumes.
    task automatic run(input int nwords, input int hp);
        rx_q.delete();
        spi_xfer(nwords, hp, nwords * 8, -1);
        chk("rx_count", rx_q.size(), nwords);
        for (int w = 0; w < nwords; w++) begin
            chk("miso_word", {24'd0, m_rx[w]}, {24'd0, exp_word()});
            chk("rx_word", (w < rx_q.size()) ? {24'd0, rx_q[w]} : 32'hxxxxxxxx, {24'd0, m_tx[w]});
        end
        void'(exp_word());
    endtask

    initial begin
        reset = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;
`ifdef SPI_SLAVE_STATUS_EN
        rx_ack = 1'b1; status_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_miso", {31'd0, miso}, 0);
        chk("reset_miso_oe", {31'd0, miso_oe}, 0);
        chk("reset_tx_ready", {31'd0, tx_ready}, 1);
        chk("reset_rx_data", {24'd0, rx_data}, 0);
        chk("reset_rx_valid", {31'd0, rx_valid}, 0);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Basic exchange.
        write_tx(8'hCC);
        m_tx[0] = 8'hAA;
        run(1, 4);
        chk("basic_tx_ready_back", {31'd0, tx_ready}, 1);

        // Back-to-back words with a refill after the first load.
        write_tx(8'hCC);
        m_tx[0] = 8'h12;
        m_tx[1] = 8'h34;
        fork
            run(2, 4);
            write_tx(8'h5A);
        join

        // Underrun.
`ifdef SPI_SLAVE_STATUS_EN
        status_clr = 1'b1;
        @(posedge clk); #1;
        status_clr = 1'b0;
        chk("underrun_cleared", {31'd0, underrun}, 0);
`endif
        m_tx[0] = 8'h0F;
        run(1, 4);
        chk("underrun_rx_data", {24'd0, rx_data}, 32'h0F);
`ifdef SPI_SLAVE_STATUS_EN
        chk("underrun_flag", {31'd0, underrun}, 1);
`endif

        // Abort after three rises: nothing received, rx_data kept.
        rx_q.delete();
        m_tx[0] = 8'($urandom);
        spi_xfer(1, 4, 3, -1);
        void'(exp_word());
        chk("abort_no_rx_valid", rx_q.size(), 0);
        chk("abort_rx_data_held", {24'd0, rx_data}, 32'h0F);
        write_tx(8'($urandom));
        m_tx[0] = 8'($urandom);
        run(1, 6);

        // Reset during bit 3, then a clean transfer.
        rx_q.delete();
        m_tx[0] = 8'h3C;
        spi_xfer(1, 4, 8, 3);
        chk("reset_mid_no_rx", rx_q.size(), 0);
        chk("reset_mid_rx_data", {24'd0, rx_data}, 0);
        m_tx[0] = 8'hA5;
        run(1, 4);

        // Fastest and slowest sclk.
        write_tx(8'h96);
        m_tx[0] = 8'h96;
        run(1, 4);
        write_tx(8'h96);
        m_tx[0] = 8'h96;
        run(1, 32);

        // Randomized transfers.
        for (int k = 0; k < 5; k++) begin
            half = $urandom_range(4, 10);
            nw   = $urandom_range(1, 2);
            wr   = 1'($urandom);
            w0   = 8'($urandom);
            w1   = 8'($urandom);
            m_tx[0] = w0;
            m_tx[1] = w1;
            if (wr) write_tx(8'($urandom));
            run(nw, half);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
